// File: rtl/mem_arbiter.sv
// Two-port (instruction fetch / data memory) arbiter in front of a single-port synchronous RAM.
// Optional macro MEM_ARB_RR_EN: round-robin tie-break in IDLE; otherwise DM has fixed priority.
module mem_arbiter #(
  parameter int ADDR_W = 10
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              IF_Req,
  input  logic [31:0]       IF_Addr,
  output logic              IF_Ack,
  output logic [31:0]       IF_DataOut,
  input  logic              DM_Req,
  input  logic              DM_WrEn,
  input  logic [31:0]       DM_Addr,
  input  logic [31:0]       DM_DataIn,
  output logic              DM_Ack,
  output logic [31:0]       DM_DataOut,
  output logic              Mem_WrEn,
  output logic [ADDR_W-1:0] Mem_Addr,
  output logic [31:0]       Mem_DataIn,
  input  logic [31:0]       Mem_DataOut
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                gnt_q, gnt_d;
  logic [ADDR_W-1:0]   addr_q;
  logic [ADDR_W-1:0]   sel_addr;

  // Winner for a fresh arbitration out of IDLE (1 = DM, 0 = IF).
  function automatic logic pick_winner(input logic if_req, input logic dm_req, input logic gnt);
`ifdef MEM_ARB_RR_EN
    if (if_req && dm_req) return ~gnt;
    return dm_req;
`else
    if (if_req && dm_req) return 1'b1;
    return dm_req;
`endif
  endfunction

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      gnt_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    case (state_q)
      IDLE: begin
        if (IF_Req || DM_Req) begin
          gnt_d   = pick_winner(IF_Req, DM_Req, gnt_q);
          state_d = ACCESS;
        end
      end
      ACCESS: state_d = DONE;
      DONE: begin
        // The requester just served is ignored; only the other side may chain straight in.
        if (gnt_q ? IF_Req : DM_Req) begin
          gnt_d   = ~gnt_q;
          state_d = ACCESS;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Address bus is live only in ACCESS and otherwise parks on the last value driven.
  assign sel_addr = gnt_q ? DM_Addr[ADDR_W+1:2] : IF_Addr[ADDR_W+1:2];
  assign Mem_Addr = (state_q == ACCESS) ? sel_addr : addr_q;

  always_ff @(posedge Clk) begin
    addr_q <= Mem_Addr;
  end

  assign Mem_WrEn   = (state_q == ACCESS) && gnt_q && DM_WrEn;
  assign Mem_DataIn = DM_DataIn;

  assign IF_Ack     = (state_q == DONE) && !gnt_q;
  assign DM_Ack     = (state_q == DONE) &&  gnt_q;
  assign IF_DataOut = IF_Ack ? Mem_DataOut : 32'h0;
  assign DM_DataOut = DM_Ack ? Mem_DataOut : 32'h0;

  wire unused_addr_bits = &{1'b0, IF_Addr[31:ADDR_W+2], IF_Addr[1:0],
                            DM_Addr[31:ADDR_W+2], DM_Addr[1:0]};

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a behavioural 1-cycle-latency RAM.
module tb_mem_arbiter;

`ifdef MEM_ARB_RR_EN
  localparam bit FIRST_IF = 1'b1;
`else
  localparam bit FIRST_IF = 1'b0;
`endif

  logic        Clk, Reset_n;
  logic        IF_Req, IF_Ack;
  logic [31:0] IF_Addr, IF_DataOut;
  logic        DM_Req, DM_WrEn, DM_Ack;
  logic [31:0] DM_Addr, DM_DataIn, DM_DataOut;
  logic        Mem_WrEn;
  logic [9:0]  Mem_Addr;
  logic [31:0] Mem_DataIn, Mem_DataOut;

  logic [31:0] ram [0:1023];
  int          n_chk = 0;
  int          n_fail = 0;
  int          wr_cnt = 0;
  int          wr_snap;

  mem_arbiter #(.ADDR_W(10)) dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .IF_Req(IF_Req), .IF_Addr(IF_Addr), .IF_Ack(IF_Ack), .IF_DataOut(IF_DataOut),
    .DM_Req(DM_Req), .DM_WrEn(DM_WrEn), .DM_Addr(DM_Addr), .DM_DataIn(DM_DataIn),
    .DM_Ack(DM_Ack), .DM_DataOut(DM_DataOut),
    .Mem_WrEn(Mem_WrEn), .Mem_Addr(Mem_Addr), .Mem_DataIn(Mem_DataIn), .Mem_DataOut(Mem_DataOut)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  always @(posedge Clk) begin
    if (Mem_WrEn) begin
      ram[Mem_Addr] <= Mem_DataIn;
      wr_cnt        <= wr_cnt + 1;
    end
    Mem_DataOut <= ram[Mem_Addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic single(input string tag, input bit dm, input bit wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [9:0] exp_addr,
                        input logic [31:0] exp_rd);
    if (dm) begin
      DM_Req = 1'b1; DM_WrEn = wr; DM_Addr = addr; DM_DataIn = wdata;
    end else begin
      IF_Req = 1'b1; IF_Addr = addr;
    end
    @(posedge Clk); @(negedge Clk);
    chk({tag, "_addr"}, 32'(Mem_Addr), 32'(exp_addr));
    chk({tag, "_wren"}, 32'(Mem_WrEn), 32'(dm & wr));
    chk({tag, "_ack_c1"}, 32'({IF_Ack, DM_Ack}), 32'(0));
    @(posedge Clk); @(negedge Clk);
    chk({tag, "_ack_c2"}, 32'({IF_Ack, DM_Ack}), dm ? 32'(2'b01) : 32'(2'b10));
    chk({tag, "_wren_c2"}, 32'(Mem_WrEn), 32'(0));
    if (!wr) chk({tag, "_data"}, dm ? DM_DataOut : IF_DataOut, exp_rd);
    IF_Req = 1'b0; DM_Req = 1'b0; DM_WrEn = 1'b0;
    @(posedge Clk); @(negedge Clk);
    chk({tag, "_ack_idle"}, 32'({IF_Ack, DM_Ack}), 32'(0));
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = 32'h0;
    ram[1]  = 32'h1111_1111;
    ram[5]  = 32'hDEAD_BEEF;
    ram[16] = 32'h0BAD_F00D;
    Reset_n = 1'b0;
    IF_Req = 1'b0; IF_Addr = 32'h0;
    DM_Req = 1'b0; DM_WrEn = 1'b0; DM_Addr = 32'h0; DM_DataIn = 32'h0;

    #12;
    chk("rst_if_ack", 32'(IF_Ack), 32'(0));
    chk("rst_dm_ack", 32'(DM_Ack), 32'(0));
    chk("rst_wren", 32'(Mem_WrEn), 32'(0));
    @(negedge Clk);
    Reset_n = 1'b1;

    // First tie after reset: DM wins with fixed priority, IF wins with round-robin.
    IF_Req = 1'b1; IF_Addr = 32'h14;
    DM_Req = 1'b1; DM_WrEn = 1'b0; DM_Addr = 32'h40;
    @(posedge Clk); @(negedge Clk);
    chk("tie_c1_addr", 32'(Mem_Addr), FIRST_IF ? 32'h5 : 32'h10);
    chk("tie_c1_ack", 32'({IF_Ack, DM_Ack}), 32'(0));
    @(posedge Clk); @(negedge Clk);
    chk("tie_c2_ack", 32'({IF_Ack, DM_Ack}), FIRST_IF ? 32'(2'b10) : 32'(2'b01));
    chk("tie_c2_data", FIRST_IF ? IF_DataOut : DM_DataOut, FIRST_IF ? 32'hDEAD_BEEF : 32'h0BAD_F00D);
    if (FIRST_IF) IF_Req = 1'b0; else DM_Req = 1'b0;
    @(posedge Clk); @(negedge Clk);
    chk("tie_c3_ack", 32'({IF_Ack, DM_Ack}), 32'(0));
    chk("tie_c3_addr", 32'(Mem_Addr), FIRST_IF ? 32'h10 : 32'h5);
    @(posedge Clk); @(negedge Clk);
    chk("tie_c4_ack", 32'({IF_Ack, DM_Ack}), FIRST_IF ? 32'(2'b01) : 32'(2'b10));
    chk("tie_c4_data", FIRST_IF ? DM_DataOut : IF_DataOut, FIRST_IF ? 32'h0BAD_F00D : 32'hDEAD_BEEF);
    IF_Req = 1'b0; DM_Req = 1'b0;
    @(posedge Clk); @(negedge Clk);
    chk("tie_idle_ack", 32'({IF_Ack, DM_Ack}), 32'(0));

    single("rd_if", 1'b0, 1'b0, 32'h14, 32'h0, 10'h005, 32'hDEAD_BEEF);
    chk("rd_if_nowrite", 32'(wr_cnt), 32'(0));
    single("wr_dm", 1'b1, 1'b1, 32'h40, 32'hCAFE_F00D, 10'h010, 32'h0);
    chk("wr_dm_count", 32'(wr_cnt), 32'(1));
    chk("wr_dm_ram", ram[16], 32'hCAFE_F00D);
    single("rd_dm", 1'b1, 1'b0, 32'h40, 32'h0, 10'h010, 32'hCAFE_F00D);
    single("rd_misal", 1'b0, 1'b0, 32'h17, 32'h0, 10'h005, 32'hDEAD_BEEF);

    // Continuous contention from IDLE with Gnt=0: DM first in both configurations.
    IF_Req = 1'b1; IF_Addr = 32'h14;
    DM_Req = 1'b1; DM_WrEn = 1'b0; DM_Addr = 32'h40;
    for (int c = 1; c <= 20; c++) begin
      @(posedge Clk); @(negedge Clk);
      chk($sformatf("cont_c%0d", c), 32'({IF_Ack, DM_Ack}),
          (c % 2 == 1) ? 32'(0) : (((c / 2) % 2 == 1) ? 32'(2'b01) : 32'(2'b10)));
    end
    IF_Req = 1'b0; DM_Req = 1'b0;
    @(posedge Clk); @(negedge Clk);
    chk("cont_idle_ack", 32'({IF_Ack, DM_Ack}), 32'(0));
    chk("cont_nowrite", 32'(wr_cnt), 32'(1));

    // Reset asserted in the middle of a DM write's ACCESS cycle.
    wr_snap = wr_cnt;
    DM_Req = 1'b1; DM_WrEn = 1'b1; DM_Addr = 32'h80; DM_DataIn = 32'h1234_5678;
    @(posedge Clk); #2;
    chk("rstw_pre_wren", 32'(Mem_WrEn), 32'(1));
    Reset_n = 1'b0;
    #1;
    chk("rstw_wren", 32'(Mem_WrEn), 32'(0));
    chk("rstw_ack", 32'(DM_Ack), 32'(0));
    DM_Req = 1'b0; DM_WrEn = 1'b0;
    @(posedge Clk); #1;
    Reset_n = 1'b1;
    chk("rstw_ram", ram[32], 32'h0);
    chk("rstw_count", 32'(wr_cnt), 32'(wr_snap));
    @(negedge Clk);
    chk("rstw_ack_after", 32'(DM_Ack), 32'(0));

    single("wrap", 1'b1, 1'b0, 32'h0000_1004, 32'h0, 10'h001, 32'h1111_1111);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
